// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU replacement engine for set-associative caches.
// Two-stage pipeline: flag read in cycle N, victim select and MRU write-back in cycle N+1.
module cache_plru_tree #(
    parameter int NUM_SETS        = 64,
    parameter int NUM_WAYS        = 8,
    parameter int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       init_done,
    input  logic                       fill_en,
    input  logic [SET_INDEX_WIDTH-1:0] fill_set,
    input  logic [NUM_WAYS-1:0]        fill_valid,
    input  logic [NUM_WAYS-1:0]        way_lock,
    output logic [WAY_INDEX_WIDTH-1:0] fill_way,
    output logic                       fill_all_locked,
    input  logic                       access_en,
    input  logic [SET_INDEX_WIDTH-1:0] access_set,
    input  logic                       update_en,
    input  logic [WAY_INDEX_WIDTH-1:0] update_way
);

    localparam int LEVELS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
    localparam int FLAG_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    generate
        if (NUM_WAYS < 1 || NUM_WAYS > 32 || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
            $error("cache_plru_tree: NUM_WAYS must be a power of two between 1 and 32");
        end
    endgenerate

    logic [FLAG_W-1:0]          flag_mem [NUM_SETS];

    logic                       init_done_q, init_done_d;
    logic [SET_INDEX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
    logic                       was_fill_q, was_fill_d;
    logic                       was_access_q, was_access_d;
    logic [SET_INDEX_WIDTH-1:0] stage_set_q, stage_set_d;
    logic [FLAG_W-1:0]          stage_flags_q, stage_flags_d;

    logic                       read_en;
    logic [SET_INDEX_WIDTH-1:0] read_set;
    logic                       wr_en;
    logic [SET_INDEX_WIDTH-1:0] wr_set;
    logic [FLAG_W-1:0]          wr_data;

    logic [NUM_WAYS-1:0]        free_ways, free_shift, sub_mask;
    logic                       free_found, go_right, left_locked, right_locked, all_locked;
    logic [FLAG_W-1:0]          flag_shift;
    logic [WAY_INDEX_WIDTH-1:0] free_way, walk_way, sel_way, new_mru;
    int                         walk_pos, walk_node, walk_span;

    logic [FLAG_W-1:0]          new_flags, upd_mask;
    logic                       upd_dir, upd_en;
    int                         mru_int, upd_node;

    always_comb begin
        init_done_d = init_done_q;
        sweep_cnt_d = sweep_cnt_q;
        if (!init_done_q) begin
            if (sweep_cnt_q == SET_INDEX_WIDTH'(NUM_SETS - 1)) begin
                init_done_d = 1'b1;
            end else begin
                sweep_cnt_d = sweep_cnt_q + SET_INDEX_WIDTH'(1);
            end
        end
    end

    // Same-set write in the read cycle is forwarded so back-to-back ops see the latest tree.
    always_comb begin
        read_en       = init_done_q & (fill_en | access_en);
        read_set      = fill_en ? fill_set : access_set;
        was_fill_d    = init_done_q & fill_en;
        was_access_d  = init_done_q & access_en & ~fill_en;
        stage_set_d   = stage_set_q;
        stage_flags_d = stage_flags_q;
        if (read_en) begin
            stage_set_d   = read_set;
            stage_flags_d = (wr_en && wr_set == read_set) ? wr_data : flag_mem[read_set];
        end
    end

    always_comb begin
        free_ways  = ~fill_valid & ~way_lock;
        all_locked = &way_lock;
        free_found = 1'b0;
        free_way   = '0;
        free_shift = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            free_shift = free_ways >> w;
            if (free_shift[0]) begin
                free_found = 1'b1;
                free_way   = WAY_INDEX_WIDTH'(w);
            end
        end

        walk_pos     = 0;
        walk_node    = 0;
        walk_span    = 0;
        sub_mask     = '0;
        flag_shift   = '0;
        go_right     = 1'b0;
        left_locked  = 1'b0;
        right_locked = 1'b0;
        // Steer away from a fully locked subtree unless the whole set is locked.
        for (int d = 0; d < LEVELS; d++) begin
            walk_node    = (1 << d) - 1 + walk_pos;
            flag_shift   = stage_flags_q >> walk_node;
            go_right     = flag_shift[0];
            walk_span    = NUM_WAYS >> (d + 1);
            sub_mask     = (NUM_WAYS'(1) << walk_span) - NUM_WAYS'(1);
            left_locked  = ((way_lock >> (2 * walk_pos * walk_span)) & sub_mask) == sub_mask;
            right_locked = ((way_lock >> ((2 * walk_pos + 1) * walk_span)) & sub_mask) == sub_mask;
            if (!all_locked) begin
                if (go_right && right_locked && !left_locked) begin
                    go_right = 1'b0;
                end else if (!go_right && left_locked && !right_locked) begin
                    go_right = 1'b1;
                end
            end
            walk_pos = 2 * walk_pos + (go_right ? 1 : 0);
        end
        walk_way = WAY_INDEX_WIDTH'(walk_pos);
        sel_way  = free_found ? free_way : walk_way;
    end

    always_comb begin
        new_mru   = was_fill_q ? sel_way : update_way;
        mru_int   = int'(new_mru);
        new_flags = stage_flags_q;
        upd_node  = 0;
        upd_mask  = '0;
        upd_dir   = 1'b0;
        for (int d = 0; d < LEVELS; d++) begin
            upd_node  = (1 << d) - 1 + (mru_int >> (LEVELS - d));
            upd_dir   = ((mru_int >> (LEVELS - 1 - d)) & 1) != 0;
            upd_mask  = FLAG_W'(1) << upd_node;
            new_flags = upd_dir ? (new_flags & ~upd_mask) : (new_flags | upd_mask);
        end
        upd_en = (was_fill_q & ~all_locked) | (was_access_q & update_en);
    end

    always_comb begin
        wr_en   = ~init_done_q | upd_en;
        wr_set  = init_done_q ? stage_set_q : sweep_cnt_q;
        wr_data = init_done_q ? new_flags : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            flag_mem[wr_set] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_done_q   <= 1'b0;
            sweep_cnt_q   <= '0;
            was_fill_q    <= 1'b0;
            was_access_q  <= 1'b0;
            stage_set_q   <= '0;
            stage_flags_q <= '0;
        end else begin
            init_done_q   <= init_done_d;
            sweep_cnt_q   <= sweep_cnt_d;
            was_fill_q    <= was_fill_d;
            was_access_q  <= was_access_d;
            stage_set_q   <= stage_set_d;
            stage_flags_q <= stage_flags_d;
        end
    end

    assign init_done       = init_done_q;
    assign fill_way        = was_fill_q ? sel_way : '0;
    assign fill_all_locked = was_fill_q & all_locked;

`ifdef SIMULATION
    logic access_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            access_prev_q <= 1'b0;
        end else begin
            access_prev_q <= access_en;
        end
    end

    always @(posedge clk) begin
        if (reset_n && init_done_q && update_en) begin
            assert (access_prev_q) else $error("update_en without access_en in the previous cycle");
        end
    end
`endif

endmodule
